id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
- Pipeline sequencer for the ID stage. It detects load-use and branch-operand hazards that ID-stage forwarding cannot cover.
- It stalls PC and IF/ID for a latched number of cycles, injects bubbles into ID/EX and flushes IF/ID on taken branches and jumps.
- It freezes the whole pipeline while data memory is busy and counts stall cycles for performance monitoring.
- It sits beside the ID forwarding unit and drives the pipeline-register enables.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- i_clk  input  1  clock; all state changes on its rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_IF_ID_Rs  input  5  ID-stage source register Rs.
- i_IF_ID_Rt  input  5  ID-stage source register Rt.
- i_ID_use_rs  input  1  ID instruction reads Rs.
- i_ID_use_rt  input  1  ID instruction reads Rt.
- i_ID_is_branch  input  1  ID instruction compares its operands in ID (beq/bne class).
- i_ID_EX_mem_read  input  1  EX-stage instruction is a load.
- i_ID_EX_reg_write  input  1  EX-stage instruction writes a register.
- i_write_register_EX  input  5  EX-stage destination register.
- i_EX_MEM_mem_read  input  1  MEM-stage instruction is a load.
- i_write_register_MEM  input  5  MEM-stage destination register.
- i_branch_taken  input  1  ID branch resolved taken.
- i_jump  input  1  ID instruction is j/jal/jr.
- i_mem_busy  input  1  data memory needs another cycle.
- o_pc_write  output  1  PC update enable.
- o_IF_ID_write  output  1  IF/ID register enable.
- o_IF_ID_flush  output  1  IF/ID becomes NOP on next edge.
- o_ID_EX_bubble  output  1  ID/EX loads NOP control on next edge.
- o_freeze  output  1  EX/MEM and MEM/WB hold.
- o_stalling  output  1  state is STALL.
- o_stall_cycles  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Match rule: a source matches a destination only if the source is used, the destination is nonzero and the register numbers are equal. Register $0 never hazards.
- Required stall count N, evaluated in RUN, first applicable rule wins:
  - i_ID_is_branch and EX load matches Rs or Rt: N=2.
  - EX load matches, not a branch: N=1.
  - Branch and i_ID_EX_reg_write (non-load) matches: N=1.
  - Branch and i_EX_MEM_mem_read with MEM destination matching: N=1.
  - Otherwise N=0.
- States: RUN, STALL. There is a 2-bit remaining-count register rem.
- RUN, N=0:
  - o_pc_write=1, o_IF_ID_write=1, o_ID_EX_bubble=0.
  - o_IF_ID_flush = i_branch_taken | i_jump.
- RUN, N>0 (stall cycle 1):
  - o_pc_write=0, o_IF_ID_write=0, o_ID_EX_bubble=1, o_IF_ID_flush=0.
  - i_branch_taken and i_jump are ignored (operands not yet valid).
  - If N=2: next state STALL, rem=1. If N=1: stay in RUN; re-evaluation next cycle finds the hazard resolved.
- STALL:
  - Outputs as for a stall cycle; hazard inputs are not re-evaluated.
  - Each non-frozen cycle decrements rem; at rem=0 after decrement, go to RUN.
  - Total stall is exactly N cycles.
- Freeze (i_mem_busy=1, highest priority, either state):
  - o_freeze=1, o_pc_write=0, o_IF_ID_write=0, o_ID_EX_bubble=0, o_IF_ID_flush=0.
  - State, rem and o_stall_cycles hold.
  - Stall detection resumes after busy drops, with the same inputs.
- o_stall_cycles increments by 1 in every non-frozen cycle in which o_ID_EX_bubble=1. It saturates at 2^CNT_W-1.
- o_stalling=1 iff state is STALL. All outputs except o_stall_cycles are combinational from state and inputs.
- Reset (asynchronous, any time including mid-STALL or mid-freeze):
  - State=RUN, rem=0, o_stall_cycles=0.
  - While i_rst=1: o_pc_write=0, o_IF_ID_write=0, o_ID_EX_bubble=1, o_IF_ID_flush=0, o_freeze=0, o_stalling=0.
  - First edge after release operates normally.

Test Plan:
- Load-use: EX lw to $8, ID add uses Rs=$8 -> exactly 1 cycle of pc_write=0 and bubble=1, o_stall_cycles=1, then pc_write=1. Same case with destination $0 -> no stall.
- Branch after load: EX lw to $9, ID beq Rt=$9 -> 2 stall cycles, o_stalling=1 in cycle 2 only. A taken branch during the stall produces no flush. The flush asserts in the first RUN cycle with i_branch_taken=1; o_stall_cycles=2.
- Branch after ALU: EX add to $3 with reg_write, ID bne Rs=$3 -> 1 stall. Branch after MEM-stage load to $3 -> 1 stall. Non-branch with an ALU-producer match -> 0 stalls.
- Jump flush: RUN, no hazard, i_jump=1 -> o_IF_ID_flush=1, pc_write=1, bubble=0 for that cycle only.
- Freeze mid-stall: enter STALL (N=2), then i_mem_busy=1 for 3 cycles -> o_freeze=1, all enables 0, o_stall_cycles holds at 1. After busy drops -> 1 more stall cycle, counter reaches 2.
- Reset mid-STALL: assert i_rst asynchronously between edges -> outputs take their reset values immediately, o_stall_cycles=0. After release, no stall unless a hazard is present. Also preload the counter with CNT_W=4 and run 20 stalls -> o_stall_cycles saturates at 15.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard sequencer: load-use / branch-operand stalls, branch/jump flush, memory-busy freeze.
// Latency: enables are combinational from state and inputs; the stall-cycle counter updates on the clock edge.
// Backpressure: i_mem_busy freezes every enable and holds all state until it drops.
module id_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_IF_ID_Rs,
    input  logic [4:0]       i_IF_ID_Rt,
    input  logic             i_ID_use_rs,
    input  logic             i_ID_use_rt,
    input  logic             i_ID_is_branch,
    input  logic             i_ID_EX_mem_read,
    input  logic             i_ID_EX_reg_write,
    input  logic [4:0]       i_write_register_EX,
    input  logic             i_EX_MEM_mem_read,
    input  logic [4:0]       i_write_register_MEM,
    input  logic             i_branch_taken,
    input  logic             i_jump,
    input  logic             i_mem_busy,
    output logic             o_pc_write,
    output logic             o_IF_ID_write,
    output logic             o_IF_ID_flush,
    output logic             o_ID_EX_bubble,
    output logic             o_freeze,
    output logic             o_stalling,
    output logic [CNT_W-1:0] o_stall_cycles
);

    typedef enum logic {RUN, STALL} state_t;

    state_t     state, state_nxt;
    logic [1:0] rem, rem_nxt;
    logic [1:0] need_n;
    logic       ex_match, mem_match;

    // Register $0 is hardwired, so a zero destination never creates a hazard.
    always_comb begin
        ex_match  = (i_write_register_EX != 5'd0) &&
                    ((i_ID_use_rs && (i_IF_ID_Rs == i_write_register_EX)) ||
                     (i_ID_use_rt && (i_IF_ID_Rt == i_write_register_EX)));
        mem_match = (i_write_register_MEM != 5'd0) &&
                    ((i_ID_use_rs && (i_IF_ID_Rs == i_write_register_MEM)) ||
                     (i_ID_use_rt && (i_IF_ID_Rt == i_write_register_MEM)));
    end

    always_comb begin
        need_n = 2'd0;
        if (i_ID_is_branch && i_ID_EX_mem_read && ex_match)
            need_n = 2'd2;
        else if (i_ID_EX_mem_read && ex_match)
            need_n = 2'd1;
        else if (i_ID_is_branch && i_ID_EX_reg_write && ex_match)
            need_n = 2'd1;
        else if (i_ID_is_branch && i_EX_MEM_mem_read && mem_match)
            need_n = 2'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= RUN;
            rem   <= 2'd0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        if (!i_mem_busy) begin
            case (state)
                RUN: begin
                    if (need_n == 2'd2) begin
                        state_nxt = STALL;
                        rem_nxt   = 2'd1;
                    end
                end
                STALL: begin
                    rem_nxt = rem - 2'd1;
                    if (rem_nxt == 2'd0)
                        state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Freeze outranks everything but reset; a stall cycle ignores branch/jump because operands are stale.
    always_comb begin
        o_pc_write     = 1'b1;
        o_IF_ID_write  = 1'b1;
        o_IF_ID_flush  = 1'b0;
        o_ID_EX_bubble = 1'b0;
        o_freeze       = 1'b0;
        o_stalling     = (state == STALL);
        if (i_rst) begin
            o_pc_write     = 1'b0;
            o_IF_ID_write  = 1'b0;
            o_ID_EX_bubble = 1'b1;
            o_stalling     = 1'b0;
        end else if (i_mem_busy) begin
            o_pc_write    = 1'b0;
            o_IF_ID_write = 1'b0;
            o_freeze      = 1'b1;
        end else if ((state == STALL) || (need_n != 2'd0)) begin
            o_pc_write     = 1'b0;
            o_IF_ID_write  = 1'b0;
            o_ID_EX_bubble = 1'b1;
        end else begin
            o_IF_ID_flush = i_branch_taken | i_jump;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_stall_cycles <= '0;
        else if (!i_mem_busy && o_ID_EX_bubble && (o_stall_cycles != {CNT_W{1'b1}}))
            o_stall_cycles <= o_stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl; output vector order is {pc_write, IF_ID_write, flush, bubble, freeze, stalling}.
module tb_id_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs, rt, wr_ex, wr_mem;
    logic          use_rs, use_rt, is_branch, ex_mem_read, ex_reg_write, mem_mem_read;
    logic          branch_taken, jump, mem_busy;
    logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze, stalling;
    logic [CW-1:0] stall_cycles;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [5:0] O_RUN   = 6'b110000;
    localparam logic [5:0] O_FLUSH = 6'b111000;
    localparam logic [5:0] O_BUB   = 6'b000100;
    localparam logic [5:0] O_STALL = 6'b000101;
    localparam logic [5:0] O_FRZ   = 6'b000010;
    localparam logic [5:0] O_FRZST = 6'b000011;

    id_hazard_ctrl #(.CNT_W(CW)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_IF_ID_Rs          (rs),
        .i_IF_ID_Rt          (rt),
        .i_ID_use_rs         (use_rs),
        .i_ID_use_rt         (use_rt),
        .i_ID_is_branch      (is_branch),
        .i_ID_EX_mem_read    (ex_mem_read),
        .i_ID_EX_reg_write   (ex_reg_write),
        .i_write_register_EX (wr_ex),
        .i_EX_MEM_mem_read   (mem_mem_read),
        .i_write_register_MEM(wr_mem),
        .i_branch_taken      (branch_taken),
        .i_jump              (jump),
        .i_mem_busy          (mem_busy),
        .o_pc_write          (pc_write),
        .o_IF_ID_write       (if_id_write),
        .o_IF_ID_flush       (if_id_flush),
        .o_ID_EX_bubble      (id_ex_bubble),
        .o_freeze            (freeze),
        .o_stalling          (stalling),
        .o_stall_cycles      (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk_out(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze, stalling};
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: outputs observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CW-1:0] exp);
        n_checks++;
        assert (stall_cycles === exp) else begin
            n_fails++;
            $error("FAIL %s: stall_cycles observed %0d expected %0d", tag, stall_cycles, exp);
        end
    endtask

    task automatic clr();
        rs = 5'd0; rt = 5'd0; wr_ex = 5'd0; wr_mem = 5'd0;
        use_rs = 1'b0; use_rt = 1'b0; is_branch = 1'b0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; mem_mem_read = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // EX-stage lw to $9 feeding the Rt operand of an ID-stage beq.
    task automatic set_branch_load();
        clr();
        is_branch = 1'b1; ex_mem_read = 1'b1; wr_ex = 5'd9; rt = 5'd9; use_rt = 1'b1;
    endtask

    task automatic set_load_use();
        clr();
        ex_mem_read = 1'b1; wr_ex = 5'd8; rs = 5'd8; use_rs = 1'b1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        #2;
        chk_out("reset_outputs", O_BUB);
        chk_cnt("reset_count", 4'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk_out("run_idle", O_RUN);

        // load-use: exactly one bubble
        set_load_use();
        #1 chk_out("load_use_stall", O_BUB);
        cyc(); clr();
        #1 chk_out("load_use_resume", O_RUN);
        chk_cnt("load_use_count", 4'd1);

        set_load_use(); wr_ex = 5'd0; rs = 5'd0;
        #1 chk_out("load_r0_no_stall", O_RUN);
        set_load_use(); use_rs = 1'b0;
        #1 chk_out("load_unused_src", O_RUN);

        // branch after load: two stalls, taken branch ignored until RUN
        set_branch_load(); branch_taken = 1'b1;
        #1 chk_out("br_load_c1", O_BUB);
        cyc();
        #1 chk_out("br_load_c2", O_STALL);
        chk_cnt("br_load_cnt_c2", 4'd2);
        cyc(); clr(); is_branch = 1'b1; branch_taken = 1'b1;
        #1 chk_out("br_load_flush", O_FLUSH);
        chk_cnt("br_load_count", 4'd3);

        // branch after ALU producer
        clr(); is_branch = 1'b1; ex_reg_write = 1'b1; wr_ex = 5'd3; rs = 5'd3; use_rs = 1'b1;
        #1 chk_out("br_alu_stall", O_BUB);
        cyc(); clr();
        #1 chk_out("br_alu_resume", O_RUN);
        chk_cnt("br_alu_count", 4'd4);

        // branch after MEM-stage load
        clr(); is_branch = 1'b1; mem_mem_read = 1'b1; wr_mem = 5'd3; rs = 5'd3; use_rs = 1'b1;
        #1 chk_out("br_memload_stall", O_BUB);
        cyc(); clr();
        #1 chk_out("br_memload_resume", O_RUN);
        chk_cnt("br_memload_count", 4'd5);

        clr(); ex_reg_write = 1'b1; wr_ex = 5'd3; rs = 5'd3; use_rs = 1'b1;
        #1 chk_out("nonbr_alu_no_stall", O_RUN);

        // jump flush for one cycle
        clr(); jump = 1'b1;
        #1 chk_out("jump_flush", O_FLUSH);
        cyc(); clr();
        #1 chk_out("jump_after", O_RUN);
        chk_cnt("jump_count", 4'd5);

        // freeze in the middle of a two-cycle stall
        set_branch_load();
        #1 chk_out("frz_c1", O_BUB);
        cyc(); mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk_out("frz_hold", O_FRZST);
            chk_cnt("frz_cnt_hold", 4'd6);
            cyc();
        end
        mem_busy = 1'b0;
        #1 chk_out("frz_resume_stall", O_STALL);
        chk_cnt("frz_cnt_after", 4'd6);
        cyc(); clr();
        #1 chk_out("frz_done", O_RUN);
        chk_cnt("frz_count", 4'd7);

        // freeze in RUN with a pending hazard: detection resumes afterwards
        set_load_use(); mem_busy = 1'b1;
        #1 chk_out("frz_run", O_FRZ);
        cyc(); mem_busy = 1'b0;
        #1 chk_out("frz_run_resume", O_BUB);
        chk_cnt("frz_run_cnt", 4'd7);
        cyc(); clr();
        #1 chk_cnt("frz_run_count", 4'd8);

        // asynchronous reset while in STALL
        set_branch_load();
        cyc();
        #1 chk_out("pre_rst_stall", O_STALL);
        #1 rst = 1'b1;
        #1 chk_out("rst_async_out", O_BUB);
        chk_cnt("rst_async_cnt", 4'd0);
        @(negedge clk);
        rst = 1'b0; clr();
        #1 chk_out("rst_release", O_RUN);
        cyc();
        #1 chk_out("rst_after_edge", O_RUN);
        chk_cnt("rst_after_cnt", 4'd0);

        // saturation: 20 consecutive bubble cycles into a 4-bit counter
        set_load_use();
        repeat (20) cyc();
        chk_cnt("sat_count", 4'd15);
        chk_out("sat_still_stalling", O_BUB);
        clr();
        cyc();
        chk_cnt("sat_hold", 4'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
